timer_reg_if: RTL

TIMER_REG_IF -- requirements
Module: timer_reg_if

---
 rtl/timer_pkg.sv | 42 ++++
 rtl/timer_apb_fsm.sv | 61 ++++++
 rtl/timer_reg_if.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer register interface.
// Contents: register byte addresses, TCR/TSR/TIE bit positions,
// the clock-divide select enum and the APB bus FSM state enum.
package timer_pkg;

  // Register byte addresses
  localparam logic [7:0] ADDR_TDR  = 8'h00;
  localparam logic [7:0] ADDR_TCR  = 8'h01;
  localparam logic [7:0] ADDR_TSR  = 8'h02;
  localparam logic [7:0] ADDR_TIE  = 8'h03;
  localparam logic [7:0] ADDR_TCNT = 8'h04;

  // TCR bit positions (CKS occupies bits TCR_CKS_HI:TCR_CKS_LO)
  localparam int TCR_LOAD   = 7;
  localparam int TCR_DIR    = 5;
  localparam int TCR_EN     = 4;
  localparam int TCR_CKS_HI = 1;
  localparam int TCR_CKS_LO = 0;

  // TSR / TIE bit positions
  localparam int TSR_OVF   = 0;
  localparam int TSR_UDF   = 1;
  localparam int TIE_OVFIE = 0;
  localparam int TIE_UDFIE = 1;

  // Counter clock divide select
  typedef enum logic [1:0] {
    CKS_DIV1 = 2'b00,
    CKS_DIV2 = 2'b01,
    CKS_DIV4 = 2'b10,
    CKS_DIV8 = 2'b11
  } cks_e;

  // APB bus FSM states
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SETUP = 2'b01,
    S_WAIT  = 2'b10,
    S_DONE  = 2'b11
  } bus_state_e;

endpackage

// File: rtl/timer_apb_fsm.sv
// APB3 slave bus sequencer for the timer register block.
// Every transfer takes exactly one wait state:
//   IDLE -> SETUP (psel & !penable) -> WAIT (penable) -> DONE -> IDLE.
// Handshake: a transfer completes only in the single cycle where
// pready=1 (state DONE); the master holds psel/paddr/pwrite/pwdata
// stable until it sees pready. Dropping psel before DONE abandons the
// transfer with no register side effect.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   psel, penable,
//   pwrite            APB control inputs
//   state             current FSM state (debug / read capture timing)
//   pready            registered, high only in DONE
//   wr_stb            registered, high in DONE of a write transfer
module timer_apb_fsm
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       psel,
  input  logic       penable,
  input  logic       pwrite,
  output bus_state_e state,
  output logic       pready,
  output logic       wr_stb
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      pready <= 1'b0;
      wr_stb <= 1'b0;
    end else begin
      pready <= 1'b0;
      wr_stb <= 1'b0;
      case (state)
        S_IDLE: begin
          if (psel && !penable) state <= S_SETUP;
        end
        S_SETUP: begin
          if (!psel)        state <= S_IDLE;
          else if (penable) state <= S_WAIT;
        end
        S_WAIT: begin
          if (!psel) begin
            state <= S_IDLE;
          end else begin
            state  <= S_DONE;
            pready <= 1'b1;
            wr_stb <= pwrite;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/timer_reg_if.sv
// Timer register interface: APB3 slave exposing TDR/TCR/TSR/TIE/TCNT
// and driving the counter core control signals.
// Register writes commit on the clock edge that ends the DONE cycle, so
// control outputs change in the cycle after DONE. Read data is captured
// on entry to DONE and is zero in every other cycle.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   psel, penable, pwrite,
//   paddr, pwdata                 APB request
//   prdata, pready, pslverr       APB response (pslverr tied 0)
//   cnt_val                       live counter value (TCNT)
//   ovf_evt, udf_evt              one-cycle event pulses from the core
//   tdr_o, load_o                 reload value and one-cycle load strobe
//   en_o, dir_o, cks_o            counter enable, direction, divide select
//   irq_o                         level interrupt
module timer_reg_if
  import timer_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  input  logic [7:0]        cnt_val,
  input  logic              ovf_evt,
  input  logic              udf_evt,
  output logic [7:0]        tdr_o,
  output logic              load_o,
  output logic              en_o,
  output logic              dir_o,
  output logic [1:0]        cks_o,
  output logic              irq_o
);

  bus_state_e bus_state;
  logic       wr_stb;

  timer_apb_fsm u_fsm (
    .clk     (clk),
    .rst     (rst),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .state   (bus_state),
    .pready  (pready),
    .wr_stb  (wr_stb)
  );

  // Register storage
  logic [7:0] tdr;
  logic       en;
  logic       dir;
  cks_e       cks;
  logic [1:0] tsr;
  logic [1:0] tie;
  logic       load;
  logic       irq;

  logic [7:0] wdata;
  logic       wr_tdr, wr_tcr, wr_tsr, wr_tie;
  logic [1:0] tsr_clr;
  logic [1:0] evt;
  logic       rd_cap;
  logic [7:0] rdata;

  assign wdata  = pwdata[7:0];
  assign wr_tdr = wr_stb && (paddr == ADDR_W'(ADDR_TDR));
  assign wr_tcr = wr_stb && (paddr == ADDR_W'(ADDR_TCR));
  assign wr_tsr = wr_stb && (paddr == ADDR_W'(ADDR_TSR));
  assign wr_tie = wr_stb && (paddr == ADDR_W'(ADDR_TIE));

  assign tsr_clr = wr_tsr ? {wdata[TSR_UDF], wdata[TSR_OVF]} : 2'b00;
  assign evt     = {udf_evt, ovf_evt};

  // Read data is sampled on the WAIT->DONE edge so it is valid in DONE.
  assign rd_cap = (bus_state == S_WAIT) && psel && !pwrite;

  always_comb begin
    rdata = 8'h00;
    if (paddr == ADDR_W'(ADDR_TDR)) begin
      rdata = tdr;
    end else if (paddr == ADDR_W'(ADDR_TCR)) begin
      rdata[TCR_DIR]                 = dir;
      rdata[TCR_EN]                  = en;
      rdata[TCR_CKS_HI:TCR_CKS_LO]   = cks;
    end else if (paddr == ADDR_W'(ADDR_TSR)) begin
      rdata[TSR_UDF] = tsr[1];
      rdata[TSR_OVF] = tsr[0];
    end else if (paddr == ADDR_W'(ADDR_TIE)) begin
      rdata[TIE_UDFIE] = tie[1];
      rdata[TIE_OVFIE] = tie[0];
    end else if (paddr == ADDR_W'(ADDR_TCNT)) begin
      rdata = cnt_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdr    <= 8'h00;
      en     <= 1'b0;
      dir    <= 1'b0;
      cks    <= CKS_DIV1;
      tsr    <= 2'b00;
      tie    <= 2'b00;
      load   <= 1'b0;
      irq    <= 1'b0;
      prdata <= '0;
    end else begin
      if (wr_tdr) tdr <= wdata;
      if (wr_tcr) begin
        en  <= wdata[TCR_EN];
        dir <= wdata[TCR_DIR];
        cks <= cks_e'(wdata[TCR_CKS_HI:TCR_CKS_LO]);
      end
      if (wr_tie) tie <= {wdata[TIE_UDFIE], wdata[TIE_OVFIE]};
      // LOAD is never stored; it only produces this one-cycle strobe.
      load <= wr_tcr && wdata[TCR_LOAD];
      // Clear first, then OR in events so a coincident event wins.
      tsr  <= (tsr & ~tsr_clr) | evt;
      irq  <= |(tsr & tie);
      prdata <= rd_cap ? DATA_W'(rdata) : '0;
    end
  end

  assign pslverr = 1'b0;
  assign tdr_o   = tdr;
  assign load_o  = load;
  assign en_o    = en;
  assign dir_o   = dir;
  assign cks_o   = cks;
  assign irq_o   = irq;

endmodule
